rob_multi_wb: RTL
=================

Name: rob_multi_wb

Overview:
- Parametrised reorder buffer for the out-of-order RV32I core; successor to the single-result ROB.
- All DEPTH slots usable: occupancy counter, no sacrificed slot.
- Accepts NUM_WB result buses per cycle, forwards operands to the issue unit, and commits in order, one entry per cycle.
- Detects branch/JALR mispredicts at commit and issues a registered flush with a redirect PC.

Parameters:
ROB_WIDTH, 3, index width; DEPTH = 2**ROB_WIDTH (power of two only)
NUM_WB, 2, number of writeback channels (ALU RS, LSB, ...)

Ports:
clk_in  in  1  clock
rst_in  in  1  asynchronous, active-low reset
rdy_in  in  1  global enable; low = hold all state
issue_valid  in  1  allocate entry this cycle
issue_op_id  in  6  opcode id from consts
issue_rd  in  5  destination register (0 = none)
issue_pc  in  32  instruction PC
issue_pred_taken  in  1  predictor decision
issue_ready  in  1  result already known (LUI/AUIPC/JAL)
issue_val  in  32  result when issue_ready
rob_full  out  1  count==DEPTH
rob_new_idx  out  ROB_WIDTH  index the next issue receives (= tail)
wb_valid  in  NUM_WB  per-channel result strobe
wb_idx  in  NUM_WB*ROB_WIDTH  target entry per channel
wb_val  in  NUM_WB*32  result value
wb_taken  in  NUM_WB  actual branch outcome
wb_target  in  NUM_WB*32  correct next PC for branch/JALR
rs1_dep, rs2_dep  in  ROB_WIDTH  lookup index
rs1_rdy, rs2_rdy  out  1  value available
rs1_val, rs2_val  out  32  value
commit_valid  out  1  one-cycle pulse
commit_idx  out  ROB_WIDTH  retired entry
commit_rd  out  5  destination register
commit_val  out  32  value for regfile
commit_is_store  out  1  release store in LSB
commit_br  out  1  retired a conditional branch (predictor update)
commit_taken  out  1  actual outcome
commit_pc  out  32  PC of retired entry
flush_out  out  1  one-cycle mispredict flush
flush_pc  out  32  redirect target

Behaviour:
- Reset (rst_in=0, async): head=tail=0, count=0, all rdy bits 0. Every output 0 except rob_new_idx=0.
- rdy_in=0: no state change; commit_valid and flush_out drive 0.
- Issue: when issue_valid && count<DEPTH, on the clock edge write entry[tail] with rdy=issue_ready and val=issue_val, then tail=tail+1 mod DEPTH. issue_valid while full is ignored (no overwrite).
- Writeback: for each channel with wb_valid, if the entry is occupied, set rdy=1 and latch val/taken/target. Writeback to an unoccupied index is ignored. Two channels hitting one index in a cycle is illegal; the highest channel index wins.
- Lookup (combinational): rsX_rdy = entry rdy OR any wb_valid with wb_idx==rsX_dep this cycle. rsX_val takes the forwarded wb_val first, otherwise the stored val.
- Commit: when count>0 and rdy[head] is registered (not same-cycle wb), pulse commit_* next edge; head=head+1 mod DEPTH.
- Mispredict: committing branch with taken!=pred_taken, or any JALR. Raise flush_out with flush_pc = target (not-taken branch: pc+4). Same edge: head=tail=0, count=0, all rdy cleared.
- Flush priority: the flush edge discards simultaneous issue and writeback.
- Simultaneous issue + commit: count unchanged; full stays full.
- Wrap-around: pointers roll DEPTH-1 -> 0 with no bubble.
- Reset mid-operation: immediate clear, outputs to reset values regardless of clock.

Decomposition:
- Shared consts package: opcode ids (JALR, branch class, store class), ROB_WIDTH default, flush-pc rule.
- One sub-module rob_operand_bypass (per-port forwarding mux over NUM_WB channels), instantiated twice.

Test Plan:
- Fill DEPTH=8 entries with no wb -> rob_full=1 after 8 issues; 9th issue ignored, rob_new_idx stays 0.
- Issue LUI with issue_ready=1, val=0x12345000 -> commit_valid next cycle, commit_rd/commit_val match, count back to 0.
- Issue idx0..2; wb ch0 idx2=5 and ch1 idx0=7 same cycle -> rs1_dep=2 reads rdy=1, val=5 combinationally. Commit order is idx0, then stall until idx1 written.
- Branch at pc=0x100, pred_taken=1, wb_taken=0 -> flush_out=1, flush_pc=0x104. Following issue gets rob_new_idx=0.
- Issue + commit every cycle for 20 cycles across wrap -> count constant, commit_idx sequence 0..7,0..
- Assert rst_in low mid-stream, between edges -> all outputs 0 immediately; no commit pulse after release.

Source files
------------

// File: rtl/rob_multi_wb_pkg.sv
// Shared opcode ids, class decoders and the mispredict redirect rule for the reorder buffer.
package rob_multi_wb_pkg;

   localparam int ROB_WIDTH_DEF = 3;
   localparam int NUM_WB_DEF    = 2;

   localparam logic [5:0] OP_LUI   = 6'd1;
   localparam logic [5:0] OP_AUIPC = 6'd2;
   localparam logic [5:0] OP_JAL   = 6'd3;
   localparam logic [5:0] OP_JALR  = 6'd4;
   localparam logic [5:0] OP_BEQ   = 6'd5;
   localparam logic [5:0] OP_BNE   = 6'd6;
   localparam logic [5:0] OP_BLT   = 6'd7;
   localparam logic [5:0] OP_BGE   = 6'd8;
   localparam logic [5:0] OP_BLTU  = 6'd9;
   localparam logic [5:0] OP_BGEU  = 6'd10;
   localparam logic [5:0] OP_LW    = 6'd13;
   localparam logic [5:0] OP_SB    = 6'd16;
   localparam logic [5:0] OP_SH    = 6'd17;
   localparam logic [5:0] OP_SW    = 6'd18;
   localparam logic [5:0] OP_ADD   = 6'd28;

   function automatic logic is_branch_op(input logic [5:0] op);
      return (op >= OP_BEQ) && (op <= OP_BGEU);
   endfunction

   function automatic logic is_store_op(input logic [5:0] op);
      return (op >= OP_SB) && (op <= OP_SW);
   endfunction

   function automatic logic is_jalr_op(input logic [5:0] op);
      return op == OP_JALR;
   endfunction

   // A branch that resolved not-taken resumes at the fall-through PC, everything else at its target.
   function automatic logic [31:0] redirect_pc(input logic jalr, input logic taken,
                                               input logic [31:0] pc, input logic [31:0] target);
      return (jalr || taken) ? target : pc + 32'd4;
   endfunction

endpackage

// File: rtl/rob_operand_bypass.sv
// Operand lookup for one issue port: a same-cycle writeback match overrides the stored entry.
// Purely combinational; the highest matching channel wins.
module rob_operand_bypass
   import rob_multi_wb_pkg::*;
#(
   parameter int ROB_WIDTH = ROB_WIDTH_DEF,
   parameter int NUM_WB    = NUM_WB_DEF
) (
   input  logic [ROB_WIDTH-1:0]        i_dep,
   input  logic [NUM_WB-1:0]           i_wb_valid,
   input  logic [NUM_WB*ROB_WIDTH-1:0] i_wb_idx,
   input  logic [NUM_WB*32-1:0]        i_wb_val,
   input  logic                        i_stored_rdy,
   input  logic [31:0]                 i_stored_val,
   output logic                        o_rdy,
   output logic [31:0]                 o_val
);

   always_comb begin
      o_rdy = i_stored_rdy;
      o_val = i_stored_val;
      for (int ch = 0; ch < NUM_WB; ch++) begin
         if (i_wb_valid[ch] && (i_wb_idx[ch*ROB_WIDTH +: ROB_WIDTH] == i_dep)) begin
            o_rdy = 1'b1;
            o_val = i_wb_val[ch*32 +: 32];
         end
      end
   end

endmodule

// File: rtl/rob_multi_wb.sv
// Reorder buffer with NUM_WB writeback buses, in-order single commit and registered mispredict flush.
// Commit/flush appear one edge after the head is ready; issue is refused only when full and not retiring.
module rob_multi_wb
   import rob_multi_wb_pkg::*;
#(
   parameter int ROB_WIDTH = ROB_WIDTH_DEF,
   parameter int NUM_WB    = NUM_WB_DEF
) (
   input  logic                        clk_in,
   input  logic                        rst_in,
   input  logic                        rdy_in,
   input  logic                        issue_valid,
   input  logic [5:0]                  issue_op_id,
   input  logic [4:0]                  issue_rd,
   input  logic [31:0]                 issue_pc,
   input  logic                        issue_pred_taken,
   input  logic                        issue_ready,
   input  logic [31:0]                 issue_val,
   output logic                        rob_full,
   output logic [ROB_WIDTH-1:0]        rob_new_idx,
   input  logic [NUM_WB-1:0]           wb_valid,
   input  logic [NUM_WB*ROB_WIDTH-1:0] wb_idx,
   input  logic [NUM_WB*32-1:0]        wb_val,
   input  logic [NUM_WB-1:0]           wb_taken,
   input  logic [NUM_WB*32-1:0]        wb_target,
   input  logic [ROB_WIDTH-1:0]        rs1_dep,
   input  logic [ROB_WIDTH-1:0]        rs2_dep,
   output logic                        rs1_rdy,
   output logic                        rs2_rdy,
   output logic [31:0]                 rs1_val,
   output logic [31:0]                 rs2_val,
   output logic                        commit_valid,
   output logic [ROB_WIDTH-1:0]        commit_idx,
   output logic [4:0]                  commit_rd,
   output logic [31:0]                 commit_val,
   output logic                        commit_is_store,
   output logic                        commit_br,
   output logic                        commit_taken,
   output logic [31:0]                 commit_pc,
   output logic                        flush_out,
   output logic [31:0]                 flush_pc
);

   localparam int DEPTH = 1 << ROB_WIDTH;

   logic [ROB_WIDTH-1:0] r_head;
   logic [ROB_WIDTH-1:0] r_tail;
   logic [ROB_WIDTH:0]   r_count;
   logic [DEPTH-1:0]     r_rdy;
   logic [DEPTH-1:0]     r_pred;
   logic [DEPTH-1:0]     r_taken;
   logic [31:0]          r_val [DEPTH];
   logic [31:0]          r_pc  [DEPTH];
   logic [31:0]          r_tgt [DEPTH];
   logic [5:0]           r_op  [DEPTH];
   logic [4:0]           r_rd  [DEPTH];

   logic                 r_commit_valid;
   logic [ROB_WIDTH-1:0] r_commit_idx;
   logic [4:0]           r_commit_rd;
   logic [31:0]          r_commit_val;
   logic                 r_commit_is_store;
   logic                 r_commit_br;
   logic                 r_commit_taken;
   logic [31:0]          r_commit_pc;
   logic                 r_flush;
   logic [31:0]          r_flush_pc;

   logic                 w_full;
   logic                 w_fire;
   logic                 w_mispred;
   logic                 w_issue;
   logic [5:0]           w_head_op;
   logic [DEPTH-1:0]     w_occ;
   logic [DEPTH-1:0]     w_wb_hit;
   logic [DEPTH-1:0]     w_wb_tk;
   logic [31:0]          w_wb_val [DEPTH];
   logic [31:0]          w_wb_tgt [DEPTH];

   assign w_full    = (r_count == (ROB_WIDTH+1)'(DEPTH));
   assign w_head_op = r_op[r_head];
   assign w_fire    = rdy_in && (r_count != '0) && r_rdy[r_head];
   assign w_mispred = w_fire && (is_jalr_op(w_head_op) ||
                      (is_branch_op(w_head_op) && (r_taken[r_head] != r_pred[r_head])));
   // Retiring the head frees its slot on the same edge, so a full buffer can still accept one issue.
   assign w_issue   = rdy_in && issue_valid && (!w_full || w_fire) && !w_mispred;

   for (genvar g = 0; g < DEPTH; g++) begin : g_occ
      logic [ROB_WIDTH-1:0] w_off;
      assign w_off    = ROB_WIDTH'(g) - r_head;
      assign w_occ[g] = ({1'b0, w_off} < r_count);
   end

   always_comb begin
      for (int i = 0; i < DEPTH; i++) begin
         w_wb_hit[i] = 1'b0;
         w_wb_tk[i]  = 1'b0;
         w_wb_val[i] = '0;
         w_wb_tgt[i] = '0;
         for (int ch = 0; ch < NUM_WB; ch++) begin
            if (wb_valid[ch] && (wb_idx[ch*ROB_WIDTH +: ROB_WIDTH] == ROB_WIDTH'(i))) begin
               w_wb_hit[i] = 1'b1;
               w_wb_tk[i]  = wb_taken[ch];
               w_wb_val[i] = wb_val[ch*32 +: 32];
               w_wb_tgt[i] = wb_target[ch*32 +: 32];
            end
         end
      end
   end

   always_ff @(posedge clk_in or negedge rst_in) begin
      if (!rst_in) begin
         r_head            <= '0;
         r_tail            <= '0;
         r_count           <= '0;
         r_rdy             <= '0;
         r_pred            <= '0;
         r_taken           <= '0;
         r_commit_valid    <= 1'b0;
         r_commit_idx      <= '0;
         r_commit_rd       <= '0;
         r_commit_val      <= '0;
         r_commit_is_store <= 1'b0;
         r_commit_br       <= 1'b0;
         r_commit_taken    <= 1'b0;
         r_commit_pc       <= '0;
         r_flush           <= 1'b0;
         r_flush_pc        <= '0;
         for (int i = 0; i < DEPTH; i++) begin
            r_val[i] <= '0;
            r_pc[i]  <= '0;
            r_tgt[i] <= '0;
            r_op[i]  <= '0;
            r_rd[i]  <= '0;
         end
      end else if (rdy_in) begin
         r_commit_valid <= w_fire;
         r_flush        <= w_mispred;
         if (w_fire) begin
            r_commit_idx      <= r_head;
            r_commit_rd       <= r_rd[r_head];
            r_commit_val      <= r_val[r_head];
            r_commit_is_store <= is_store_op(w_head_op);
            r_commit_br       <= is_branch_op(w_head_op);
            r_commit_taken    <= r_taken[r_head];
            r_commit_pc       <= r_pc[r_head];
         end
         if (w_mispred) begin
            r_flush_pc <= redirect_pc(is_jalr_op(w_head_op), r_taken[r_head],
                                      r_pc[r_head], r_tgt[r_head]);
            r_head     <= '0;
            r_tail     <= '0;
            r_count    <= '0;
            r_rdy      <= '0;
         end else begin
            if (w_fire) r_head <= r_head + ROB_WIDTH'(1);
            for (int i = 0; i < DEPTH; i++) begin
               if (w_wb_hit[i] && w_occ[i]) begin
                  r_rdy[i]   <= 1'b1;
                  r_val[i]   <= w_wb_val[i];
                  r_taken[i] <= w_wb_tk[i];
                  r_tgt[i]   <= w_wb_tgt[i];
               end
            end
            // Issue is written last so it overrides a stale writeback to the slot it reuses.
            if (w_issue) begin
               r_rdy[r_tail]   <= issue_ready;
               r_val[r_tail]   <= issue_val;
               r_pred[r_tail]  <= issue_pred_taken;
               r_taken[r_tail] <= 1'b0;
               r_tgt[r_tail]   <= '0;
               r_pc[r_tail]    <= issue_pc;
               r_op[r_tail]    <= issue_op_id;
               r_rd[r_tail]    <= issue_rd;
               r_tail          <= r_tail + ROB_WIDTH'(1);
            end
            r_count <= r_count + (ROB_WIDTH+1)'(w_issue) - (ROB_WIDTH+1)'(w_fire);
         end
      end else begin
         r_commit_valid <= 1'b0;
         r_flush        <= 1'b0;
      end
   end

   rob_operand_bypass #(.ROB_WIDTH(ROB_WIDTH), .NUM_WB(NUM_WB)) u_bypass_rs1 (
      .i_dep        (rs1_dep),
      .i_wb_valid   (wb_valid),
      .i_wb_idx     (wb_idx),
      .i_wb_val     (wb_val),
      .i_stored_rdy (r_rdy[rs1_dep]),
      .i_stored_val (r_val[rs1_dep]),
      .o_rdy        (rs1_rdy),
      .o_val        (rs1_val)
   );

   rob_operand_bypass #(.ROB_WIDTH(ROB_WIDTH), .NUM_WB(NUM_WB)) u_bypass_rs2 (
      .i_dep        (rs2_dep),
      .i_wb_valid   (wb_valid),
      .i_wb_idx     (wb_idx),
      .i_wb_val     (wb_val),
      .i_stored_rdy (r_rdy[rs2_dep]),
      .i_stored_val (r_val[rs2_dep]),
      .o_rdy        (rs2_rdy),
      .o_val        (rs2_val)
   );

   assign rob_full        = w_full;
   assign rob_new_idx     = r_tail;
   assign commit_valid    = r_commit_valid & rdy_in;
   assign commit_idx      = r_commit_idx;
   assign commit_rd       = r_commit_rd;
   assign commit_val      = r_commit_val;
   assign commit_is_store = r_commit_is_store;
   assign commit_br       = r_commit_br;
   assign commit_taken    = r_commit_taken;
   assign commit_pc       = r_commit_pc;
   assign flush_out       = r_flush & rdy_in;
   assign flush_pc        = r_flush_pc;

endmodule
